fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS32 core. It owns the PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency. It honours the stall signals PCWrite/IFID_Write produced by the hazard unit and the taken-branch redirect, and it delivers instruction and PC+4 to the ID stage. It sits directly upstream of ID, which holds the main control decoder and the load-use hazard detection.

---
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS32 core.
// Owns the PC, runs the req/ack fetch handshake and applies stalls and branch redirects.
module fetch_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFID_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCplus4,
  output logic        IFID_Valid
);

  localparam int unsigned DataW = 32;
  localparam logic [DataW-1:0] ResetPc  = 32'h0000_0000;
  localparam logic [DataW-1:0] NopInstr = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           stateQ, stateD;
  logic [DataW-1:0] pcQ, pcD;
  logic [DataW-1:0] holdInstrQ, holdInstrD;
  logic [DataW-1:0] redirectPcQ, redirectPcD;
  logic [DataW-1:0] instrQ, instrD;
  logic [DataW-1:0] pcPlus4Q, pcPlus4D;
  logic             validQ, validD;

  logic             stall;
  logic [DataW-1:0] pcNext;
  logic [DataW-1:0] target;

  assign stall  = !(PCWrite && IFID_Write);
  assign pcNext = pcQ + DataW'(4);
  assign target = branch_target & ~DataW'(3);

  // Request decodes from state only; HOLD is the only state without a pending fetch.
  assign imem_req  = !reset && (stateQ != HOLD);
  assign imem_addr = pcQ;

  assign IFID_Instr   = instrQ;
  assign IFID_PCplus4 = pcPlus4Q;
  assign IFID_Valid   = validQ;

  // Next-state and next-register logic; a branch redirect always beats a stall.
  always_comb begin
    stateD      = stateQ;
    pcD         = pcQ;
    holdInstrD  = holdInstrQ;
    redirectPcD = redirectPcQ;
    instrD      = instrQ;
    pcPlus4D    = pcPlus4Q;
    validD      = validQ;

    unique case (stateQ)
      FETCH: begin
        if (imem_ack) begin
          if (branch_taken) begin
            pcD      = target;
            instrD   = NopInstr;
            pcPlus4D = '0;
            validD   = 1'b0;
          end else if (!stall) begin
            instrD   = imem_rdata;
            pcPlus4D = pcNext;
            validD   = 1'b1;
            pcD      = pcNext;
          end else begin
            holdInstrD = imem_rdata;
            stateD     = HOLD;
          end
        end else if (branch_taken) begin
          redirectPcD = target;
          instrD      = NopInstr;
          pcPlus4D    = '0;
          validD      = 1'b0;
          stateD      = DRAIN;
        end else if (IFID_Write) begin
          instrD   = NopInstr;
          pcPlus4D = '0;
          validD   = 1'b0;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pcD        = target;
          holdInstrD = '0;
          instrD     = NopInstr;
          pcPlus4D   = '0;
          validD     = 1'b0;
          stateD     = FETCH;
        end else if (!stall) begin
          instrD   = holdInstrQ;
          pcPlus4D = pcNext;
          validD   = 1'b1;
          pcD      = pcNext;
          stateD   = FETCH;
        end
      end

      DRAIN: begin
        // Keep the stale request up until memory acks it, then jump to the latest target.
        if (branch_taken) begin
          redirectPcD = target;
        end
        if (branch_taken || IFID_Write) begin
          instrD   = NopInstr;
          pcPlus4D = '0;
          validD   = 1'b0;
        end
        if (imem_ack) begin
          pcD    = branch_taken ? target : redirectPcQ;
          stateD = FETCH;
        end
      end

      default: stateD = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ      <= FETCH;
      pcQ         <= ResetPc;
      holdInstrQ  <= '0;
      redirectPcQ <= '0;
      instrQ      <= NopInstr;
      pcPlus4Q    <= '0;
      validQ      <= 1'b0;
    end else begin
      stateQ      <= stateD;
      pcQ         <= pcD;
      holdInstrQ  <= holdInstrD;
      redirectPcQ <= redirectPcD;
      instrQ      <= instrD;
      pcPlus4Q    <= pcPlus4D;
      validQ      <= validD;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns addr ^ 32'hA5A5_0000
// and ack is driven per step to model zero-wait or multi-cycle latency.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        IFID_Write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCplus4;
  logic        IFID_Valid;

  int passed = 0;
  int total  = 0;

  fetch_stage dut (
    .clock        (clock),
    .reset        (reset),
    .PCWrite      (PCWrite),
    .IFID_Write   (IFID_Write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .IFID_Instr   (IFID_Instr),
    .IFID_PCplus4 (IFID_PCplus4),
    .IFID_Valid   (IFID_Valid)
  );

  always #5 clock = ~clock;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chkIfid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic valid);
    chk({tag, ".instr"}, IFID_Instr, instr);
    chk({tag, ".pc4"}, IFID_PCplus4, pc4);
    chk({tag, ".valid"}, 32'(IFID_Valid), 32'(valid));
  endtask

  initial begin
    reset = 1'b1; PCWrite = 1'b1; IFID_Write = 1'b1;
    branch_taken = 1'b0; branch_target = '0; imem_ack = 1'b0;

    // Reset state
    tick();
    chk("rst.req", 32'(imem_req), 32'd0);
    chkIfid("rst", 32'h0, 32'h0, 1'b0);
    reset = 1'b0; imem_ack = 1'b1;
    #1;
    chk("first.req", 32'(imem_req), 32'd1);
    chk("first.addr", imem_addr, 32'h0);

    // Zero-wait stream
    tick(); chkIfid("zw0", 32'hA5A5_0000, 32'h4, 1'b1); chk("zw0.addr", imem_addr, 32'h4);
    tick(); chkIfid("zw1", 32'hA5A5_0004, 32'h8, 1'b1); chk("zw1.addr", imem_addr, 32'h8);

    // Load-use stall for one cycle while fetching 0x8
    PCWrite = 1'b0; IFID_Write = 1'b0;
    tick(); chkIfid("stall", 32'hA5A5_0004, 32'h8, 1'b1); chk("stall.req", 32'(imem_req), 32'd0);
    PCWrite = 1'b1; IFID_Write = 1'b1;
    tick(); chkIfid("rel", 32'hA5A5_0008, 32'hC, 1'b1);
    chk("rel.req", 32'(imem_req), 32'd1); chk("rel.addr", imem_addr, 32'hC);
    tick(); chkIfid("zw2", 32'hA5A5_000C, 32'h10, 1'b1); chk("zw2.addr", imem_addr, 32'h10);

    // Zero-wait branch at 0x10 to 0x40
    branch_taken = 1'b1; branch_target = 32'h40;
    tick(); chkIfid("br", 32'h0, 32'h0, 1'b0); chk("br.addr", imem_addr, 32'h40);
    branch_taken = 1'b0;
    tick(); chkIfid("brT", 32'hA5A5_0040, 32'h44, 1'b1); chk("brT.addr", imem_addr, 32'h44);

    // 3-cycle latency at 0x44
    imem_ack = 1'b0;
    tick(); chkIfid("lat0", 32'h0, 32'h0, 1'b0); chk("lat0.addr", imem_addr, 32'h44);
    tick(); chkIfid("lat1", 32'h0, 32'h0, 1'b0); chk("lat1.addr", imem_addr, 32'h44);
    imem_ack = 1'b1;
    tick(); chkIfid("lat2", 32'hA5A5_0044, 32'h48, 1'b1); chk("lat2.addr", imem_addr, 32'h48);

    // Branch during outstanding request at 0x48
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    tick(); chkIfid("dr0", 32'h0, 32'h0, 1'b0);
    chk("dr0.req", 32'(imem_req), 32'd1); chk("dr0.addr", imem_addr, 32'h48);
    branch_taken = 1'b0;
    tick(); chk("dr1.addr", imem_addr, 32'h48);
    imem_ack = 1'b1;
    tick(); chk("dr2.addr", imem_addr, 32'h80); chk("dr2.valid", 32'(IFID_Valid), 32'd0);

    // Second branch during drain overwrites target
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    tick(); chk("dd0.addr", imem_addr, 32'h80);
    branch_target = 32'hC0;
    tick(); chk("dd1.addr", imem_addr, 32'h80);
    branch_taken = 1'b0; imem_ack = 1'b1;
    tick(); chk("dd2.addr", imem_addr, 32'hC0);

    // Branch coinciding with drain ack wins; low target bits are cleared
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    tick(); chk("dc0.addr", imem_addr, 32'hC0);
    imem_ack = 1'b1; branch_target = 32'h303;
    tick(); chk("dc1.addr", imem_addr, 32'h300);
    branch_taken = 1'b0;
    tick(); chkIfid("dc2", 32'hA5A5_0300, 32'h304, 1'b1); chk("dc2.addr", imem_addr, 32'h304);

    // Branch during HOLD drops held instruction
    PCWrite = 1'b0;
    tick(); chk("hb0.req", 32'(imem_req), 32'd0); chk("hb0.pc4", IFID_PCplus4, 32'h304);
    branch_taken = 1'b1; branch_target = 32'h500;
    tick(); chkIfid("hb1", 32'h0, 32'h0, 1'b0); chk("hb1.addr", imem_addr, 32'h500);
    branch_taken = 1'b0; PCWrite = 1'b1;
    tick(); chkIfid("hb2", 32'hA5A5_0500, 32'h504, 1'b1);

    // Reset in the middle of a drain
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h600;
    tick(); chk("rd0.addr", imem_addr, 32'h504);
    branch_taken = 1'b0; reset = 1'b1;
    tick(); chk("rd1.req", 32'(imem_req), 32'd0); chkIfid("rd1", 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    #1; chk("rd2.addr", imem_addr, 32'h0); chk("rd2.req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    tick(); chkIfid("rd3", 32'hA5A5_0000, 32'h4, 1'b1);

    // PC+4 wraps at the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick(); chk("wr0.addr", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    tick(); chkIfid("wr1", 32'h5A5A_FFFC, 32'h0, 1'b1); chk("wr1.addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
